// File: rtl/uop_exec_sequencer_pkg.sv
// MicroCode word layout and load/store selector types shared by the decoder,
// the execution sequencer and the functional units.
package uop_exec_sequencer_pkg;

  typedef enum logic {
    LSU_LOAD  = 1'b0,
    LSU_STORE = 1'b1
  } lsu_funct_e;

  typedef enum logic [1:0] {
    LSU_BYTE = 2'd0,
    LSU_HALF = 2'd1,
    LSU_WORD = 2'd2
  } lsu_bytes_e;

  typedef enum logic [1:0] {
    RD_ALU = 2'd0,
    RD_CSR = 2'd1,
    RD_LD  = 2'd2,
    RD_PC4 = 2'd3
  } rd_src_e;

  typedef struct packed {
    logic       en;
    logic [3:0] funct;
  } alu_ctrl_t;

  typedef struct packed {
    logic       en;
    logic [2:0] funct;
  } br_ctrl_t;

  typedef struct packed {
    logic        en;
    logic [1:0]  funct;
    logic [11:0] addr;
  } csr_ctrl_t;

  typedef struct packed {
    logic       en;
    lsu_funct_e funct;
    lsu_bytes_e bytes;
    logic       sign_ext;
  } lsu_ctrl_t;

  typedef struct packed {
    alu_ctrl_t  alu;
    br_ctrl_t   br_unit;
    csr_ctrl_t  csr_unit;
    lsu_ctrl_t  ld_st_unit;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rd_addr;
    logic       rd_en;
    rd_src_e    rd_src;
  } micro_code_t;

endpackage

// File: rtl/uop_exec_sequencer.sv
// Executes one decoded MicroCode word at a time: holds it for the ALU/branch/CSR
// units, runs an optional load/store transaction, then writes back rd and the next PC.
//
// state | meaning
// IDLE  | ready for the next uop
// EXEC  | uop_q drives the units; their results are sampled
// MEM   | lsu_req held until lsu_ack or timeout
// WB    | rd_we / pc_next_valid strobe for one cycle
module uop_exec_sequencer
  import uop_exec_sequencer_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            uop_valid,
  output logic            uop_ready,
  input  micro_code_t     uop,
  input  logic [XLEN-1:0] uop_pc,
  output micro_code_t     uop_q,
  output logic [XLEN-1:0] pc_q,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] csr_rdata,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  output logic            lsu_req,
  output logic [XLEN-1:0] lsu_addr,
  output logic [XLEN-1:0] lsu_wdata,
  output lsu_funct_e      lsu_funct,
  output lsu_bytes_e      lsu_bytes,
  input  logic            lsu_ack,
  input  logic [XLEN-1:0] lsu_rdata,
  output logic            rd_we,
  output logic [4:0]      rd_waddr,
  output logic [XLEN-1:0] rd_wdata,
  output logic            pc_next_valid,
  output logic [XLEN-1:0] pc_next,
  output logic            mem_err
);

  localparam int unsigned TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MEM  = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic            w_accept;
  logic            w_mem_done;
  logic            w_mem_tmo;
  logic            w_tmo_hit;
  logic            w_rd_we_ok;
  logic [XLEN-1:0] w_pc4;

  logic            r_uop_ready;
  micro_code_t     r_uop_q;
  logic [XLEN-1:0] r_pc_q;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_csr;
  logic            r_br_taken;
  logic [XLEN-1:0] r_br_target;
  logic [XLEN-1:0] r_ld_data;
  logic [TW-1:0]   r_tmo_cnt;
  logic            r_lsu_req;
  logic [XLEN-1:0] r_lsu_addr;
  logic [XLEN-1:0] r_lsu_wdata;
  lsu_funct_e      r_lsu_funct;
  lsu_bytes_e      r_lsu_bytes;
  logic            r_rd_we;
  logic [4:0]      r_rd_waddr;
  logic [XLEN-1:0] r_rd_wdata;
  logic            r_pc_next_valid;
  logic [XLEN-1:0] r_pc_next;
  logic            r_mem_err;

  function automatic logic [XLEN-1:0] f_wdata(input rd_src_e         src,
                                              input logic [XLEN-1:0] alu,
                                              input logic [XLEN-1:0] csr,
                                              input logic [XLEN-1:0] ld,
                                              input logic [XLEN-1:0] pc4);
    logic [XLEN-1:0] v;
    case (src)
      RD_CSR:  v = csr;
      RD_LD:   v = ld;
      RD_PC4:  v = pc4;
      default: v = alu;
    endcase
    return v;
  endfunction

  assign w_pc4      = r_pc_q + XLEN'(4);
  assign w_rd_we_ok = r_uop_q.rd_en && (r_uop_q.rd_addr != 5'd0);
  assign w_tmo_hit  = (MEM_TIMEOUT != 0) && (r_tmo_cnt == TW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_mem_done  = 1'b0;
    w_mem_tmo   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_uop_ready && uop_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = r_uop_q.ld_st_unit.en ? S_MEM : S_WB;
      end
      S_MEM: begin
        // An ack in the final allowed cycle still completes the access.
        if (lsu_ack) begin
          w_mem_done  = 1'b1;
          w_state_nxt = S_WB;
        end else if (w_tmo_hit) begin
          w_mem_tmo   = 1'b1;
          w_state_nxt = S_WB;
        end
      end
      S_WB: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uop_ready     <= 1'b0;
      r_uop_q         <= '0;
      r_pc_q          <= '0;
      r_alu           <= '0;
      r_csr           <= '0;
      r_br_taken      <= 1'b0;
      r_br_target     <= '0;
      r_ld_data       <= '0;
      r_tmo_cnt       <= '0;
      r_lsu_req       <= 1'b0;
      r_lsu_addr      <= '0;
      r_lsu_wdata     <= '0;
      r_lsu_funct     <= LSU_LOAD;
      r_lsu_bytes     <= LSU_BYTE;
      r_rd_we         <= 1'b0;
      r_rd_waddr      <= '0;
      r_rd_wdata      <= '0;
      r_pc_next_valid <= 1'b0;
      r_pc_next       <= '0;
      r_mem_err       <= 1'b0;
    end else begin
      r_uop_ready     <= (w_state_nxt == S_IDLE);
      r_lsu_req       <= (w_state_nxt == S_MEM);
      r_rd_we         <= 1'b0;
      r_pc_next_valid <= 1'b0;

      if (w_accept) begin
        r_uop_q <= uop;
        r_pc_q  <= uop_pc;
      end

      if (r_state == S_EXEC) begin
        r_alu       <= alu_result;
        r_csr       <= csr_rdata;
        r_br_taken  <= br_taken;
        r_br_target <= br_target;
        if (r_uop_q.ld_st_unit.en) begin
          r_lsu_addr  <= alu_result;
          r_lsu_wdata <= rs2_data;
          r_lsu_funct <= r_uop_q.ld_st_unit.funct;
          r_lsu_bytes <= r_uop_q.ld_st_unit.bytes;
          r_tmo_cnt   <= TW'(MEM_TIMEOUT);
        end else begin
          r_rd_we         <= w_rd_we_ok;
          r_rd_waddr      <= r_uop_q.rd_addr;
          r_rd_wdata      <= f_wdata(r_uop_q.rd_src, alu_result, csr_rdata, r_ld_data, w_pc4);
          r_pc_next       <= (r_uop_q.br_unit.en && br_taken) ? br_target : w_pc4;
          r_pc_next_valid <= 1'b1;
        end
      end

      if (r_state == S_MEM) begin
        r_tmo_cnt <= r_tmo_cnt - TW'(1);
        if (w_mem_done) begin
          r_ld_data       <= lsu_rdata;
          r_rd_we         <= w_rd_we_ok;
          r_rd_waddr      <= r_uop_q.rd_addr;
          r_rd_wdata      <= f_wdata(r_uop_q.rd_src, r_alu, r_csr, lsu_rdata, w_pc4);
          r_pc_next       <= (r_uop_q.br_unit.en && r_br_taken) ? r_br_target : w_pc4;
          r_pc_next_valid <= 1'b1;
        end
        if (w_mem_tmo) begin
          r_mem_err       <= 1'b1;
          r_rd_waddr      <= r_uop_q.rd_addr;
          r_pc_next       <= w_pc4;
          r_pc_next_valid <= 1'b1;
        end
      end
    end
  end

  assign uop_ready     = r_uop_ready;
  assign uop_q         = r_uop_q;
  assign pc_q          = r_pc_q;
  assign lsu_req       = r_lsu_req;
  assign lsu_addr      = r_lsu_addr;
  assign lsu_wdata     = r_lsu_wdata;
  assign lsu_funct     = r_lsu_funct;
  assign lsu_bytes     = r_lsu_bytes;
  assign rd_we         = r_rd_we;
  assign rd_waddr      = r_rd_waddr;
  assign rd_wdata      = r_rd_wdata;
  assign pc_next_valid = r_pc_next_valid;
  assign pc_next       = r_pc_next;
  assign mem_err       = r_mem_err;

endmodule

// File: tb/tb_uop_exec_sequencer.sv
// Scoreboard bench for uop_exec_sequencer: the driver pushes the expected writeback of
// each accepted uop, a negedge monitor pops and compares when the strobe appears.
module tb_uop_exec_sequencer;
  import uop_exec_sequencer_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uop_valid;
  logic        uop_ready;
  micro_code_t uop;
  logic [31:0] uop_pc;
  micro_code_t uop_q;
  logic [31:0] pc_q;
  logic [31:0] rs2_data, alu_result, csr_rdata, br_target;
  logic        br_taken;
  logic        lsu_req;
  logic [31:0] lsu_addr, lsu_wdata;
  lsu_funct_e  lsu_funct;
  lsu_bytes_e  lsu_bytes;
  logic        lsu_ack;
  logic [31:0] lsu_rdata;
  logic        rd_we;
  logic [4:0]  rd_waddr;
  logic [31:0] rd_wdata;
  logic        pc_next_valid;
  logic [31:0] pc_next;
  logic        mem_err;

  uop_exec_sequencer #(.XLEN(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .uop_valid(uop_valid), .uop_ready(uop_ready), .uop(uop), .uop_pc(uop_pc),
    .uop_q(uop_q), .pc_q(pc_q),
    .rs2_data(rs2_data), .alu_result(alu_result), .csr_rdata(csr_rdata),
    .br_taken(br_taken), .br_target(br_target),
    .lsu_req(lsu_req), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_funct(lsu_funct), .lsu_bytes(lsu_bytes),
    .lsu_ack(lsu_ack), .lsu_rdata(lsu_rdata),
    .rd_we(rd_we), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .pc_next_valid(pc_next_valid), .pc_next(pc_next), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    micro_code_t u;
    logic [31:0] pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc_next;
    logic        tmo;
    logic [31:0] addr;
    logic [31:0] st_data;
    int          lat;
    int          req_cyc;
    int          n_acc;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          ack_after = -1;
  logic [31:0] mem_rdata = '0;
  logic        exp_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic finish_sim;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  endtask

  function automatic micro_code_t mk_uop(input int kind);
    micro_code_t u;
    u = '0;
    u.alu.funct     = 4'($urandom);
    u.csr_unit.addr = 12'($urandom);
    u.rs1_addr      = 5'($urandom);
    u.rs2_addr      = 5'($urandom);
    u.rd_addr       = 5'($urandom);
    u.rd_en         = 1'($urandom);
    case ($urandom_range(0, 2))
      0:       u.ld_st_unit.bytes = LSU_BYTE;
      1:       u.ld_st_unit.bytes = LSU_HALF;
      default: u.ld_st_unit.bytes = LSU_WORD;
    endcase
    case (kind)
      0: begin u.alu.en = 1'b1; u.rd_src = RD_ALU; end
      1: begin u.csr_unit.en = 1'b1; u.rd_src = RD_CSR; end
      2: begin u.br_unit.en = 1'b1; u.br_unit.funct = 3'($urandom); u.rd_src = RD_PC4; end
      3: begin
        u.alu.en = 1'b1; u.ld_st_unit.en = 1'b1; u.ld_st_unit.funct = LSU_LOAD;
        u.rd_src = RD_LD;
      end
      default: begin
        u.alu.en = 1'b1; u.ld_st_unit.en = 1'b1; u.ld_st_unit.funct = LSU_STORE;
        u.rd_en = 1'b0; u.rd_src = RD_ALU;
      end
    endcase
    return u;
  endfunction

  // Drives one uop once the sequencer is ready and records what the writeback must be.
  task automatic issue(input micro_code_t u, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] csr, input logic tk, input logic [31:0] tgt,
                       input logic [31:0] rs2, input int ack_a, input logic [31:0] rdat);
    exp_t        e;
    int          w;
    logic [31:0] pc4;
    w = 0;
    @(negedge clk);
    while (!uop_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", 64'(uop_ready), 64'(1'b1));
    if (!uop_ready) finish_sim();
    uop = u; uop_pc = pc; alu_result = alu; csr_rdata = csr;
    br_taken = tk; br_target = tgt; rs2_data = rs2;
    ack_after = ack_a; mem_rdata = rdat;
    uop_valid = 1'b1;
    @(posedge clk);
    #1;
    pc4       = pc + 32'd4;
    e.u       = u;
    e.pc      = pc;
    e.tmo     = u.ld_st_unit.en && (ack_a < 0 || ack_a + 1 > TMO);
    e.we      = u.rd_en && (u.rd_addr != 5'd0) && !e.tmo;
    e.waddr   = u.rd_addr;
    case (u.rd_src)
      RD_CSR:  e.wdata = csr;
      RD_LD:   e.wdata = rdat;
      RD_PC4:  e.wdata = pc4;
      default: e.wdata = alu;
    endcase
    e.pc_next = (!e.tmo && u.br_unit.en && tk) ? tgt : pc4;
    e.addr    = alu;
    e.st_data = rs2;
    if (!u.ld_st_unit.en) begin
      e.lat = 2; e.req_cyc = 0;
    end else if (e.tmo) begin
      e.lat = 2 + TMO; e.req_cyc = TMO;
    end else begin
      e.lat = 3 + ack_a; e.req_cyc = ack_a + 1;
    end
    e.n_acc = cyc;
    sb.push_back(e);
    // A different word offered while busy must be ignored.
    uop = mk_uop(0);
    uop_pc = 32'($urandom);
    @(posedge clk);
    #1;
    uop_valid = 1'b0;
  endtask

  // Memory responder: acks after ack_after request cycles, never when negative.
  initial begin
    int resp_cnt;
    resp_cnt = 0;
    lsu_ack = 1'b0;
    lsu_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !lsu_req) begin
        lsu_ack = 1'b0;
        resp_cnt = 0;
      end else begin
        if (ack_after >= 0 && resp_cnt == ack_after) begin
          lsu_ack = 1'b1;
          lsu_rdata = mem_rdata;
        end else begin
          lsu_ack = 1'b0;
          lsu_rdata = $urandom;
        end
        resp_cnt++;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t e;
    int   req_cnt;
    logic prev_valid;
    req_cnt = 0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_cnt = 0;
        prev_valid = 1'b0;
      end else begin
        if (lsu_req) begin
          req_cnt++;
          if (sb.size() == 0) begin
            chk("lsu_req_unexpected", 64'(1'b1), 64'(1'b0));
          end else begin
            chk("lsu_addr", 64'(lsu_addr), 64'(sb[0].addr));
            chk("lsu_wdata", 64'(lsu_wdata), 64'(sb[0].st_data));
            chk("lsu_funct", 64'(lsu_funct), 64'(sb[0].u.ld_st_unit.funct));
            chk("lsu_bytes", 64'(lsu_bytes), 64'(sb[0].u.ld_st_unit.bytes));
            chk("ready_in_mem", 64'(uop_ready), 64'(1'b0));
          end
        end
        if (rd_we && !pc_next_valid) chk("rd_we_without_strobe", 64'(1'b1), 64'(1'b0));
        if (pc_next_valid) begin
          chk("strobe_width", 64'(prev_valid), 64'(1'b0));
          if (sb.size() == 0) begin
            chk("spurious_strobe", 64'(1'b1), 64'(1'b0));
          end else begin
            e = sb.pop_front();
            chk("latency", 64'(cyc + 1 - e.n_acc), 64'(e.lat));
            chk("rd_we", 64'(rd_we), 64'(e.we));
            if (e.we) begin
              chk("rd_waddr", 64'(rd_waddr), 64'(e.waddr));
              chk("rd_wdata", 64'(rd_wdata), 64'(e.wdata));
            end
            chk("pc_next", 64'(pc_next), 64'(e.pc_next));
            chk("req_cycles", 64'(req_cnt), 64'(e.req_cyc));
            chk("uop_q", 64'(uop_q), 64'(e.u));
            chk("pc_q", 64'(pc_q), 64'(e.pc));
            if (e.tmo) exp_err = 1'b1;
            chk("mem_err", 64'(mem_err), 64'(exp_err));
            chk("ready_in_wb", 64'(uop_ready), 64'(1'b0));
          end
          req_cnt = 0;
        end
        prev_valid = pc_next_valid;
      end
    end
  end

  initial begin
    #200000;
    chk("watchdog", 64'(1'b1), 64'(1'b0));
    finish_sim();
  end

  initial begin
    micro_code_t u;
    int          w;
    uop_valid = 1'b0; uop = '0; uop_pc = '0;
    rs2_data = '0; alu_result = '0; csr_rdata = '0; br_taken = 1'b0; br_target = '0;
    #20;
    chk("rst_uop_ready", 64'(uop_ready), 64'(1'b0));
    chk("rst_lsu_req", 64'(lsu_req), 64'(1'b0));
    chk("rst_rd_we", 64'(rd_we), 64'(1'b0));
    chk("rst_pc_next_valid", 64'(pc_next_valid), 64'(1'b0));
    chk("rst_mem_err", 64'(mem_err), 64'(1'b0));
    chk("rst_uop_q", 64'(uop_q), 64'(0));
    chk("rst_pc_next", 64'(pc_next), 64'(0));
    chk("rst_lsu_addr", 64'(lsu_addr), 64'(0));
    #8 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_before_first_edge", 64'(uop_ready), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("ready_after_first_edge", 64'(uop_ready), 64'(1'b1));

    // ADDI-like
    u = mk_uop(0); u.rd_addr = 5'd5; u.rd_en = 1'b1;
    issue(u, 32'h100, 32'h0000_1234, 32'h55, 1'b1, 32'h999, 32'h0, -1, 32'h0);
    // word load, ack in the third request cycle
    u = mk_uop(3); u.rd_addr = 5'd7; u.rd_en = 1'b1; u.ld_st_unit.bytes = LSU_WORD;
    issue(u, 32'h104, 32'h2000, 32'h0, 1'b0, 32'h0, 32'h1111, 2, 32'hDEAD_BEEF);
    // taken and not-taken branch
    u = mk_uop(2); u.rd_en = 1'b0;
    issue(u, 32'h200, 32'h0, 32'h0, 1'b1, 32'h180, 32'h0, -1, 32'h0);
    issue(u, 32'h200, 32'h0, 32'h0, 1'b0, 32'h180, 32'h0, -1, 32'h0);
    // JAL to x0, then PC+4 wrap into x1
    u = mk_uop(2); u.rd_addr = 5'd0; u.rd_en = 1'b1;
    issue(u, 32'h300, 32'h0, 32'h0, 1'b1, 32'h400, 32'h0, -1, 32'h0);
    u = mk_uop(2); u.rd_addr = 5'd1; u.rd_en = 1'b1;
    issue(u, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 32'h400, 32'h0, -1, 32'h0);
    // immediate ack on the first MEM cycle
    u = mk_uop(3); u.rd_addr = 5'd9; u.rd_en = 1'b1;
    issue(u, 32'h500, 32'h2040, 32'h0, 1'b0, 32'h0, 32'h2222, 0, 32'h0BAD_F00D);
    // store that never gets acked
    u = mk_uop(4);
    issue(u, 32'h600, 32'h3000, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D, -1, 32'h0);
    u = mk_uop(1); u.rd_addr = 5'd3; u.rd_en = 1'b1;
    issue(u, 32'h604, 32'h0, 32'h0ABC_0123, 1'b0, 32'h0, 32'h0, -1, 32'h0);

    // async reset in the middle of a memory access
    u = mk_uop(3); u.rd_addr = 5'd4; u.rd_en = 1'b1;
    issue(u, 32'h700, 32'h4000, 32'h0, 1'b0, 32'h0, 32'h0, -1, 32'h0);
    w = 0;
    while (!lsu_req && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("req_before_reset", 64'(lsu_req), 64'(1'b1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_lsu_req", 64'(lsu_req), 64'(1'b0));
    chk("rst_async_rd_we", 64'(rd_we), 64'(1'b0));
    chk("rst_async_pc_next_valid", 64'(pc_next_valid), 64'(1'b0));
    chk("rst_async_mem_err", 64'(mem_err), 64'(1'b0));
    sb.delete();
    exp_err = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_mid_reset", 64'(uop_ready), 64'(1'b1));
    chk("mem_err_after_reset", 64'(mem_err), 64'(1'b0));

    for (int i = 0; i < 60; i++) begin
      u = mk_uop(int'($urandom_range(0, 4)));
      issue(u, $urandom & 32'hFFFF_FFFC, $urandom, $urandom, 1'($urandom), $urandom, $urandom,
            int'($urandom_range(0, 5)), $urandom);
    end

    w = 0;
    while (sb.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("drain", 64'(sb.size()), 64'(0));
    repeat (3) @(negedge clk);
    finish_sim();
  end

endmodule
